wb_copy_master: RTL and testbench

WB_COPY_MASTER -- requirements
Module: wb_copy_master

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_copy_buffer.sv | 33 +++
 rtl/wb_copy_master.sv | 188 ++++++++++++++++++
 tb/tb_wb_copy_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: copy-master state encoding and bus width constants.
package wb_pkg;

  localparam int unsigned WB_BYTE_W    = 8;
  localparam int unsigned WB_ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_GAP1  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP2  = 3'd4
  } copy_state_e;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_copy_buffer.sv
// Count x DataWidth staging buffer: one synchronous write port, one async read port.
module wb_copy_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Count     = 4,
  localparam int unsigned IdxWidth = idx_width(Count)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IdxWidth-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [IdxWidth-1:0]  raddr,
  output logic [DataWidth-1:0] rdata
);

  localparam logic [IdxWidth-1:0] IDX_LAST = IdxWidth'(Count - 1);

  logic [DataWidth-1:0] mem [Count];

  // Storage: cleared on reset, one word written per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (we && (waddr <= IDX_LAST)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= IDX_LAST) ? mem[raddr] : '0;

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone pipelined copy master: reads Count words from SrcBase, writes them to DstBase, repeats while enabled.
module wb_copy_master
  import wb_pkg::*;
#(
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          Count         = 4,
  parameter logic [AddrWidth-1:0] SrcBase       = AddrWidth'(32'h2000_0000),
  parameter logic [AddrWidth-1:0] DstBase       = AddrWidth'(32'h1000_0000),
  parameter int unsigned          GapCycles     = 1,
  parameter int unsigned          TimeoutCycles = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DataWidth-1:0]          bus_data_s,
  input  logic                          bus_ack,
  input  logic                          bus_stall,
  input  logic                          bus_err,
  output logic [DataWidth-1:0]          bus_data_m,
  output logic [AddrWidth-1:0]          bus_addr,
  output logic [DataWidth/WB_BYTE_W-1:0] bus_sel,
  output logic                          bus_cyc,
  output logic                          bus_stb,
  output logic                          bus_we,
  output logic                          busy,
  output logic [WB_ERR_CNT_W-1:0]       err_count
);

  localparam int unsigned CW = $clog2(Count + 1);
  localparam int unsigned IW = idx_width(Count);
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);

  localparam logic [CW-1:0]           CNT      = CW'(Count);
  localparam logic [CW-1:0]           CNT_LAST = CW'(Count - 1);
  localparam logic [TW-1:0]           TMO_LAST = TW'(TimeoutCycles - 1);
  localparam logic [7:0]              GAP_LAST = 8'(GapCycles - 1);
  localparam logic [AddrWidth-1:0]    STRIDE   = AddrWidth'(DataWidth / WB_BYTE_W);
  localparam logic [WB_ERR_CNT_W-1:0] ERR_MAX  = '1;

  copy_state_e state, state_next, after_phase;

  logic [CW-1:0]        issued, acked;
  logic [TW-1:0]        tmo;
  logic [7:0]           gap;
  logic                 in_phase, in_gap, take_ack, abort, done, issue, gap_end, leave;
  logic                 buf_we;
  logic [IW-1:0]        wr_idx, rd_idx;
  logic [DataWidth-1:0] rd_data;

  // Phase bookkeeping; an error (or timeout) beats a same-cycle ack.
  assign in_phase = (state == ST_READ) || (state == ST_WRITE);
  assign in_gap   = (state == ST_GAP1) || (state == ST_GAP2);
  assign take_ack = in_phase && bus_ack && !bus_err && (acked < CNT);
  assign abort    = in_phase && (bus_err || (!bus_ack && (tmo == TMO_LAST)));
  assign done     = take_ack && (acked == CNT_LAST);
  assign issue    = bus_stb && !bus_stall;
  assign gap_end  = (gap == GAP_LAST);
  assign busy     = (state != ST_IDLE);

  // Where a finished or aborted phase goes when the trailing gap is zero length.
  assign after_phase = (GapCycles == 0) ? (enable ? ST_READ : ST_IDLE) : ST_GAP2;

  assign buf_we = (state == ST_READ) && take_ack;
  assign wr_idx = IW'(acked);
  assign rd_idx = (issued < CNT) ? IW'(issued) : '0;

  wb_copy_buffer #(
    .DataWidth (DataWidth),
    .Count     (Count)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .waddr (wr_idx),
    .wdata (bus_data_s),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and combinational bus outputs; leave marks any exit so counters restart.
  always_comb begin
    state_next = state;
    leave      = 1'b0;
    bus_cyc    = 1'b0;
    bus_stb    = 1'b0;
    bus_we     = 1'b0;
    bus_sel    = '0;
    bus_addr   = '0;
    bus_data_m = '0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_READ;
          leave      = 1'b1;
        end
      end
      ST_READ: begin
        bus_cyc  = 1'b1;
        bus_stb  = (issued < CNT);
        bus_sel  = '1;
        bus_addr = SrcBase + AddrWidth'(issued) * STRIDE;
        if (abort) begin
          state_next = after_phase;
          leave      = 1'b1;
        end else if (done) begin
          state_next = (GapCycles == 0) ? ST_WRITE : ST_GAP1;
          leave      = 1'b1;
        end
      end
      ST_GAP1: begin
        if (gap_end) begin
          state_next = ST_WRITE;
          leave      = 1'b1;
        end
      end
      ST_WRITE: begin
        bus_cyc    = 1'b1;
        bus_stb    = (issued < CNT);
        bus_we     = 1'b1;
        bus_sel    = '1;
        bus_addr   = DstBase + AddrWidth'(issued) * STRIDE;
        bus_data_m = rd_data;
        if (abort || done) begin
          state_next = after_phase;
          leave      = 1'b1;
        end
      end
      ST_GAP2: begin
        if (gap_end) begin
          state_next = enable ? ST_READ : ST_IDLE;
          leave      = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        leave      = 1'b1;
      end
    endcase
  end

  // Request/ack/timeout/gap counters, all restarted on every state exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued <= '0;
      acked  <= '0;
      tmo    <= '0;
      gap    <= '0;
    end else if (leave) begin
      issued <= '0;
      acked  <= '0;
      tmo    <= '0;
      gap    <= '0;
    end else begin
      if (issue) begin
        issued <= issued + CW'(1);
      end
      if (take_ack) begin
        acked <= acked + CW'(1);
      end
      if (in_phase) begin
        tmo <= bus_ack ? '0 : tmo + TW'(1);
      end
      if (in_gap) begin
        gap <= gap + 8'd1;
      end
    end
  end

  // Saturating count of abandoned phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (abort && (err_count != ERR_MAX)) begin
      err_count <= err_count + WB_ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Randomized bench for wb_copy_master: pipelined slave model plus a transaction-level copy model.
module tb_wb_copy_master;

  localparam int          CNT = 4;
  localparam int          GAP = 1;
  localparam int          TMO = 64;
  localparam logic [31:0] SRC = 32'h2000_0000;
  localparam logic [31:0] DST = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] bus_data_s;
  logic        bus_ack;
  logic        bus_stall;
  logic        bus_err;
  logic [31:0] bus_data_m;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic        busy;
  logic [7:0]  err_count;

  wb_copy_master #(
    .DataWidth     (32),
    .AddrWidth     (32),
    .Count         (CNT),
    .SrcBase       (SRC),
    .DstBase       (DST),
    .GapCycles     (GAP),
    .TimeoutCycles (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus_data_s (bus_data_s),
    .bus_ack    (bus_ack),
    .bus_stall  (bus_stall),
    .bus_err    (bus_err),
    .bus_data_m (bus_data_m),
    .bus_addr   (bus_addr),
    .bus_sel    (bus_sel),
    .bus_cyc    (bus_cyc),
    .bus_stb    (bus_stb),
    .bus_we     (bus_we),
    .busy       (busy),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepted requests as seen on the bus, and in-flight requests awaiting ack.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } req_t;

  req_t        log_q[$];
  req_t        pend_q[$];
  logic [31:0] rom [4];
  logic [31:0] dst [4];

  int stall_mode      = 0;
  int max_lat         = 1;
  bit no_ack          = 1'b0;
  int err_at_read_ack = 0;
  int read_acks       = 0;
  int err_cycle       = -1;

  // Pipelined slave: in-order acks after a random latency, optional stalls, error injection.
  initial begin : slave
    req_t        p;
    logic [31:0] off;
    logic [1:0]  idx;
    int          stall_cnt;
    bit          prev_stalled;
    logic [31:0] prev_addr;
    stall_cnt    = 0;
    prev_stalled = 1'b0;
    prev_addr    = '0;
    bus_ack      = 1'b0;
    bus_stall    = 1'b0;
    bus_err      = 1'b0;
    bus_data_s   = '0;
    forever begin
      @(negedge clk);
      bus_ack    = 1'b0;
      bus_err    = 1'b0;
      bus_stall  = 1'b0;
      bus_data_s = '0;
      if (reset || !bus_cyc) begin
        pend_q.delete();
        stall_cnt    = 0;
        prev_stalled = 1'b0;
      end else begin
        if (prev_stalled) begin
          check("stall_addr_hold", 64'(bus_addr), 64'(prev_addr));
          check("stall_stb_hold", 64'(bus_stb), 64'd1);
        end
        if (!no_ack && pend_q.size() > 0 && pend_q[0].cyc <= cycle) begin
          p = pend_q.pop_front();
          bus_ack = 1'b1;
          if (!p.we) begin
            off        = p.addr - SRC;
            idx        = off[3:2];
            bus_data_s = rom[idx];
            read_acks++;
            if (read_acks == err_at_read_ack) begin
              bus_err   = 1'b1;
              err_cycle = cycle;
            end
          end else begin
            off      = p.addr - DST;
            idx      = off[3:2];
            dst[idx] = p.data;
          end
        end
        if (bus_stb) begin
          case (stall_mode)
            1: bus_stall = ($urandom_range(0, 2) == 0);
            2: begin
              if (stall_cnt < 2) begin
                bus_stall = 1'b1;
                stall_cnt++;
              end else begin
                stall_cnt = 0;
              end
            end
            default: bus_stall = 1'b0;
          endcase
          if (!bus_stall) begin
            log_q.push_back('{we: bus_we, addr: bus_addr, data: bus_data_m, cyc: cycle});
            pend_q.push_back('{we: bus_we, addr: bus_addr, data: bus_data_m,
                               cyc: cycle + int'($urandom_range(1, 32'(max_lat)))});
          end
          prev_stalled = bus_stall;
          prev_addr    = bus_addr;
        end else begin
          prev_stalled = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig_val(input int which);
    case (which)
      0:       return busy;
      1:       return bus_cyc;
      default: return bus_we;
    endcase
  endfunction

  // Bounded wait for a signal level; an expired budget shows up as a failed check.
  task automatic wait_sig(input int which, input logic val, input int budget, input string tag);
    int i;
    i = 0;
    while (sig_val(which) !== val && i < budget) begin
      step();
      i++;
    end
    check(tag, 64'(sig_val(which)), 64'(val));
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One full copy loop; model: reads SRC+4k in order, then writes rom[k] to DST+4k.
  task automatic run_copy(input bit drop_in_write, input bit fixed_rom, input string tag);
    for (int k = 0; k < CNT; k++) begin
      rom[k] = fixed_rom ? 32'(k + 1) : $urandom;
      dst[k] = '0;
    end
    log_q.delete();
    enable = 1'b1;
    wait_sig(0, 1'b1, 10, {tag, "_start"});
    if (drop_in_write) wait_sig(2, 1'b1, 500, {tag, "_reach_write"});
    enable = 1'b0;
    wait_sig(0, 1'b0, 600, {tag, "_idle"});
    check({tag, "_nreq"}, 64'(log_q.size()), 64'(2 * CNT));
    if (log_q.size() == 2 * CNT) begin
      for (int k = 0; k < CNT; k++) begin
        check($sformatf("%s_rd_we%0d", tag, k), 64'(log_q[k].we), 64'd0);
        check($sformatf("%s_rd_addr%0d", tag, k), 64'(log_q[k].addr), 64'(SRC + 32'(4 * k)));
        check($sformatf("%s_wr_we%0d", tag, k), 64'(log_q[CNT + k].we), 64'd1);
        check($sformatf("%s_wr_addr%0d", tag, k), 64'(log_q[CNT + k].addr), 64'(DST + 32'(4 * k)));
        check($sformatf("%s_wr_data%0d", tag, k), 64'(log_q[CNT + k].data), 64'(rom[k]));
      end
    end
    for (int k = 0; k < CNT; k++) begin
      check($sformatf("%s_dst%0d", tag, k), 64'(dst[k]), 64'(rom[k]));
    end
  endtask

  initial begin : main
    int i;
    int n;
    int falls;
    int early_writes;
    logic prev;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    check("rst_cyc", 64'(bus_cyc), 64'd0);
    check("rst_stb", 64'(bus_stb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_addr", 64'(bus_addr), 64'd0);
    reset = 1'b0;
    step();

    // Zero-wait ROM holding 1..4: back-to-back reads, writes after ack latency plus gap.
    stall_mode = 0;
    max_lat    = 1;
    run_copy(1'b0, 1'b1, "zw");
    if (log_q.size() == 2 * CNT) begin
      for (int k = 1; k < CNT; k++) begin
        check($sformatf("zw_rd_cyc%0d", k), 64'(log_q[k].cyc - log_q[0].cyc), 64'(k));
        check($sformatf("zw_wr_cyc%0d", k), 64'(log_q[CNT + k].cyc - log_q[CNT].cyc), 64'(k));
      end
      check("zw_gap", 64'(log_q[CNT].cyc - log_q[CNT - 1].cyc), 64'(2 + GAP));
    end

    // Two stall cycles per request.
    stall_mode = 2;
    max_lat    = 1;
    run_copy(1'b0, 1'b0, "stall2");

    // Random stalls and ack latencies.
    for (int r = 0; r < 6; r++) begin
      stall_mode = int'($urandom_range(0, 2));
      max_lat    = int'($urandom_range(1, 4));
      run_copy(1'b0, 1'b0, $sformatf("rnd%0d", r));
    end

    // Enable dropped during the write phase: loop still completes.
    stall_mode = 1;
    max_lat    = 2;
    run_copy(1'b1, 1'b0, "drop_wr");
    check("drop_wr_busy", 64'(busy), 64'd0);
    check("clean_err_count", 64'(err_count), 64'd0);

    // Error on the second read ack.
    do_reset();
    stall_mode      = 0;
    max_lat         = 1;
    read_acks       = 0;
    err_cycle       = -1;
    err_at_read_ack = 2;
    for (int k = 0; k < CNT; k++) begin
      rom[k] = $urandom;
      dst[k] = '0;
    end
    log_q.delete();
    enable = 1'b1;
    i = 0;
    while (err_cycle < 0 && i < 100) begin
      step();
      i++;
    end
    err_at_read_ack = 0;
    check("err_seen", 64'(err_cycle >= 0), 64'd1);
    step();
    check("err_cyc_drop", 64'(bus_cyc), 64'd0);
    check("err_stb_drop", 64'(bus_stb), 64'd0);
    check("err_count1", 64'(err_count), 64'd1);
    for (int g = 1; g < GAP; g++) begin
      step();
      check("err_gap_cyc", 64'(bus_cyc), 64'd0);
    end
    step();
    check("err_restart", 64'(bus_cyc), 64'd1);
    early_writes = 0;
    foreach (log_q[j]) if (log_q[j].we && log_q[j].cyc <= err_cycle) early_writes++;
    check("err_no_write", 64'(early_writes), 64'd0);
    enable = 1'b0;
    wait_sig(0, 1'b0, 600, "err_idle");
    check("err_count_after", 64'(err_count), 64'd1);
    for (int k = 0; k < CNT; k++) begin
      check($sformatf("err_retry_dst%0d", k), 64'(dst[k]), 64'(rom[k]));
    end

    // Slave never acks: phase abandoned after TMO cycles; 300 repeats saturate the counter.
    do_reset();
    no_ack     = 1'b1;
    stall_mode = 0;
    enable     = 1'b1;
    wait_sig(1, 1'b1, 10, "to_start");
    n = 0;
    while (bus_cyc && n < 200) begin
      step();
      n++;
    end
    check("to_len", 64'(n), 64'(TMO));
    check("to_err1", 64'(err_count), 64'd1);
    falls = 0;
    prev  = bus_cyc;
    i     = 0;
    while (falls < 299 && i < 30000) begin
      step();
      i++;
      if (prev && !bus_cyc) falls++;
      prev = bus_cyc;
    end
    check("to_falls", 64'(falls), 64'd299);
    check("to_err255", 64'(err_count), 64'd255);
    enable = 1'b0;
    wait_sig(0, 1'b0, 200, "to_idle");
    no_ack = 1'b0;

    // Reset in the middle of a read phase.
    for (int k = 0; k < CNT; k++) rom[k] = $urandom;
    enable = 1'b1;
    wait_sig(1, 1'b1, 10, "rr_start");
    step();
    check("rr_pre_cyc", 64'(bus_cyc), 64'd1);
    reset = 1'b1;
    step();
    check("rr_cyc", 64'(bus_cyc), 64'd0);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_err_count", 64'(err_count), 64'd0);
    check("rr_stb", 64'(bus_stb), 64'd0);
    enable = 1'b0;
    repeat (3) begin
      step();
      check("rr_stb_hold", 64'(bus_stb), 64'd0);
    end
    reset = 1'b0;
    step();
    check("rr_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
